// File: rtl/mpu_issue_sched.sv
// Two-port issue scheduler for the MPU. It arbitrates between the ports round-robin,
// stalls on slot occupancy and vector-register hazards, and registers the issued command.
module mpu_issue_sched #(
  parameter  int VR_IND_WTH   = 4,
  parameter  int MRX_IND_WTH  = 5,
  parameter  int MRX_ADDR_WTH = 9,
  localparam int CMD_WTH      = 10 + 2 * (MRX_IND_WTH + MRX_ADDR_WTH) + VR_IND_WTH
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req0_valid_i,
  input  logic [CMD_WTH-1:0]      req0_cmd_i,
  output logic                    req0_ready_o,
  input  logic                    req1_valid_i,
  input  logic [CMD_WTH-1:0]      req1_cmd_i,
  output logic                    req1_ready_o,
  output logic [1:0]              mpu_code_o,
  output logic                    mpu_type_o,
  output logic [MRX_IND_WTH-1:0]  mpu_mrs0_index_o,
  output logic [MRX_ADDR_WTH-1:0] mpu_mrs0_addr_o,
  output logic [MRX_IND_WTH-1:0]  mpu_mrs1_index_o,
  output logic [MRX_ADDR_WTH-1:0] mpu_mrs1_addr_o,
  output logic [VR_IND_WTH-1:0]   mpu_vrd_index_o,
  output logic [6:0]              mpu_mac_len_o,
  output logic                    err_o,
  output logic                    idle_o
);

  localparam int NVR     = 1 << VR_IND_WTH;
  localparam int O_MRS0A = MRX_IND_WTH;
  localparam int O_MRS1I = MRX_IND_WTH + MRX_ADDR_WTH;
  localparam int O_MRS1A = 2 * MRX_IND_WTH + MRX_ADDR_WTH;
  localparam int O_VRD   = 2 * (MRX_IND_WTH + MRX_ADDR_WTH);
  localparam int O_LEN   = O_VRD + VR_IND_WTH;
  localparam int O_TYPE  = O_LEN + 7;
  localparam int O_CODE  = O_TYPE + 1;

  // Handshake: a command transfers on a rising edge where valid and ready are both high.
  // Ready never depends on the other port's ready and is held low while rstn_i is low.

  logic                    ptr_q, ptr_d;
  logic [6:0]              slot_q, slot_d;
  logic [7:0]              drain_q, drain_d;
  logic [7:0]              hz_q [NVR];
  logic [7:0]              hz_d [NVR];
  logic [1:0]              code_q, code_d;
  logic                    err_q, err_d;
  logic                    type_q;
  logic [MRX_IND_WTH-1:0]  mrs0i_q, mrs1i_q;
  logic [MRX_ADDR_WTH-1:0] mrs0a_q, mrs1a_q;
  logic [VR_IND_WTH-1:0]   vrd_q;
  logic [6:0]              len_q;

  logic [1:0]              code0, code1, sel_code;
  logic [VR_IND_WTH-1:0]   vrd0, vrd1, sel_vrd;
  logic                    haz0, haz1, elig0, elig1, grant0, grant1;
  logic                    accept, issue, sel_mmac;
  logic [CMD_WTH-1:0]      sel_cmd;
  logic [7:0]              len_ext, len_m1, drain_dec, drain_floor;

  always_comb begin
    code0  = req0_cmd_i[O_CODE +: 2];
    code1  = req1_cmd_i[O_CODE +: 2];
    vrd0   = req0_cmd_i[O_VRD +: VR_IND_WTH];
    vrd1   = req1_cmd_i[O_VRD +: VR_IND_WTH];
    haz0   = (code0 == 2'd3) && (hz_q[vrd0] != 8'd0);
    haz1   = (code1 == 2'd3) && (hz_q[vrd1] != 8'd0);
    elig0  = rstn_i && req0_valid_i && (slot_q == 7'd0) && !haz0;
    elig1  = rstn_i && req1_valid_i && (slot_q == 7'd0) && !haz1;
    grant0 = elig0 && (!ptr_q || !elig1);
    grant1 = elig1 && (ptr_q || !elig0);
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_comb begin
    accept   = grant0 || grant1;
    sel_cmd  = grant1 ? req1_cmd_i : req0_cmd_i;
    sel_code = sel_cmd[O_CODE +: 2];
    sel_vrd  = sel_cmd[O_VRD +: VR_IND_WTH];
    // Codes 1 and 3 are the only legal ones; bit 0 identifies them.
    issue    = accept && sel_code[0];
    sel_mmac = sel_code == 2'd3;
    // A length field of zero encodes 128.
    len_ext  = (sel_cmd[O_LEN +: 7] == 7'd0) ? 8'd128 : {1'b0, sel_cmd[O_LEN +: 7]};
    len_m1   = len_ext - 8'd1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant0) ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;

    slot_d = (slot_q != 7'd0) ? slot_q - 7'd1 : 7'd0;
    if (issue) slot_d = sel_mmac ? len_m1[6:0] : 7'd0;

    drain_dec   = (drain_q != 8'd0) ? drain_q - 8'd1 : 8'd0;
    drain_floor = sel_mmac ? len_ext + 8'd17 : 8'd18;
    drain_d     = drain_dec;
    if (issue && (drain_floor > drain_dec)) drain_d = drain_floor;

    for (int i = 0; i < NVR; i++) begin
      hz_d[i] = (hz_q[i] != 8'd0) ? hz_q[i] - 8'd1 : 8'd0;
      if (issue && (sel_vrd == VR_IND_WTH'(i))) hz_d[i] = sel_mmac ? len_ext + 8'd1 : 8'd2;
    end

    code_d = issue ? sel_code : 2'd0;
    err_d  = accept && !sel_code[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr_q   <= 1'b0;
      slot_q  <= '0;
      drain_q <= '0;
      for (int i = 0; i < NVR; i++) hz_q[i] <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      type_q  <= 1'b0;
      mrs0i_q <= '0;
      mrs0a_q <= '0;
      mrs1i_q <= '0;
      mrs1a_q <= '0;
      vrd_q   <= '0;
      len_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      drain_q <= drain_d;
      for (int i = 0; i < NVR; i++) hz_q[i] <= hz_d[i];
      code_q  <= code_d;
      err_q   <= err_d;
      // Operand fields stay put between issues; illegal commands leave them untouched.
      if (issue) begin
        type_q  <= sel_cmd[O_TYPE];
        mrs0i_q <= sel_cmd[0 +: MRX_IND_WTH];
        mrs0a_q <= sel_cmd[O_MRS0A +: MRX_ADDR_WTH];
        mrs1i_q <= sel_cmd[O_MRS1I +: MRX_IND_WTH];
        mrs1a_q <= sel_cmd[O_MRS1A +: MRX_ADDR_WTH];
        vrd_q   <= sel_vrd;
        len_q   <= sel_cmd[O_LEN +: 7];
      end
    end
  end

  assign mpu_code_o       = code_q;
  assign mpu_type_o       = type_q;
  assign mpu_mrs0_index_o = mrs0i_q;
  assign mpu_mrs0_addr_o  = mrs0a_q;
  assign mpu_mrs1_index_o = mrs1i_q;
  assign mpu_mrs1_addr_o  = mrs1a_q;
  assign mpu_vrd_index_o  = vrd_q;
  assign mpu_mac_len_o    = len_q;
  assign err_o            = err_q;
  assign idle_o           = (drain_q == 8'd0) && (slot_q == 7'd0) && !issue;

endmodule

// File: tb/tb_mpu_issue_sched.sv
// Bench for mpu_issue_sched: single-command vector table, hand-written multi-cycle
// sequences, and an issue scoreboard comparing every presented command with what was handed over.
module tb_mpu_issue_sched;

  localparam int CMD_W = 42;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0_valid, req1_valid;
  logic [CMD_W-1:0] req0_cmd, req1_cmd;
  logic             req0_ready_o, req1_ready_o;
  logic [1:0]       mpu_code_o;
  logic             mpu_type_o;
  logic [4:0]       mpu_mrs0_index_o, mpu_mrs1_index_o;
  logic [8:0]       mpu_mrs0_addr_o, mpu_mrs1_addr_o;
  logic [3:0]       mpu_vrd_index_o;
  logic [6:0]       mpu_mac_len_o;
  logic             err_o, idle_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [CMD_W-1:0] exp_q[$];

  mpu_issue_sched dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_valid_i(req0_valid), .req0_cmd_i(req0_cmd), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid), .req1_cmd_i(req1_cmd), .req1_ready_o(req1_ready_o),
    .mpu_code_o(mpu_code_o), .mpu_type_o(mpu_type_o),
    .mpu_mrs0_index_o(mpu_mrs0_index_o), .mpu_mrs0_addr_o(mpu_mrs0_addr_o),
    .mpu_mrs1_index_o(mpu_mrs1_index_o), .mpu_mrs1_addr_o(mpu_mrs1_addr_o),
    .mpu_vrd_index_o(mpu_vrd_index_o), .mpu_mac_len_o(mpu_mac_len_o),
    .err_o(err_o), .idle_o(idle_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] code, input logic typ,
                                               input logic [6:0] len, input logic [3:0] vrd);
    logic [4:0] m0i, m1i;
    logic [8:0] m0a, m1a;
    m0i = 5'($urandom_range(0, 31));
    m1i = 5'($urandom_range(0, 31));
    m0a = 9'($urandom_range(0, 511));
    m1a = 9'($urandom_range(0, 511));
    return {code, typ, len, vrd, m1a, m1i, m0a, m0i};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      at_neg();
      if (idle_o) begin
        tick();
        return;
      end
      tick();
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  // Scoreboard: push on handshake, pop when a command is presented
  always @(negedge clk) begin
    if (rstn) begin
      if (mpu_code_o != 2'd0) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_issue", mpu_code_o, 0);
        end else begin
          chk("sb_issue_fields",
              {mpu_code_o, mpu_type_o, mpu_mac_len_o, mpu_vrd_index_o, mpu_mrs1_addr_o,
               mpu_mrs1_index_o, mpu_mrs0_addr_o, mpu_mrs0_index_o},
              exp_q.pop_front());
        end
      end
      if (req0_valid && req0_ready_o && req0_cmd[CMD_W-2]) exp_q.push_back(req0_cmd);
      if (req1_valid && req1_ready_o && req1_cmd[CMD_W-2]) exp_q.push_back(req1_cmd);
    end
  end

  typedef struct {
    logic [1:0] code;
    logic       typ;
    logic [6:0] len;
    logic [3:0] vrd;
    int         exp_gap;
    int         exp_idle;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [CMD_W-1:0] cmd_a;
    int gap, off;

    vecs[0] = '{code: 2'd1, typ: 1'b0, len: 7'd9,  vrd: 4'd1,  exp_gap: 1,   exp_idle: 20,  exp_err: 1'b0};
    vecs[1] = '{code: 2'd3, typ: 1'b0, len: 7'd4,  vrd: 4'd3,  exp_gap: 4,   exp_idle: 23,  exp_err: 1'b0};
    vecs[2] = '{code: 2'd3, typ: 1'b0, len: 7'd1,  vrd: 4'd6,  exp_gap: 1,   exp_idle: 20,  exp_err: 1'b0};
    vecs[3] = '{code: 2'd3, typ: 1'b1, len: 7'd3,  vrd: 4'd9,  exp_gap: 3,   exp_idle: 22,  exp_err: 1'b0};
    vecs[4] = '{code: 2'd3, typ: 1'b0, len: 7'd20, vrd: 4'd15, exp_gap: 20,  exp_idle: 39,  exp_err: 1'b0};
    vecs[5] = '{code: 2'd3, typ: 1'b1, len: 7'd0,  vrd: 4'd0,  exp_gap: 128, exp_idle: 147, exp_err: 1'b0};
    vecs[6] = '{code: 2'd0, typ: 1'b0, len: 7'd5,  vrd: 4'd2,  exp_gap: 1,   exp_idle: 20,  exp_err: 1'b1};
    vecs[7] = '{code: 2'd2, typ: 1'b1, len: 7'd5,  vrd: 4'd4,  exp_gap: 1,   exp_idle: 20,  exp_err: 1'b1};

    // Reset state, with requests pending during reset
    rstn = 1'b0;
    req0_valid = 1'b1; req0_cmd = mk_cmd(2'd1, 1'b0, 7'd0, 4'd1);
    req1_valid = 1'b1; req1_cmd = mk_cmd(2'd3, 1'b0, 7'd4, 4'd2);
    tick(); tick();
    at_neg();
    chk("rst_ready0", req0_ready_o, 0);
    chk("rst_ready1", req1_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fields",
        {mpu_code_o, mpu_type_o, mpu_mac_len_o, mpu_vrd_index_o, mpu_mrs1_addr_o,
         mpu_mrs1_index_o, mpu_mrs0_addr_o, mpu_mrs0_index_o}, 0);
    tick();
    rstn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    at_neg();
    chk("rel_idle", idle_o, 1);
    chk("rel_code", mpu_code_o, 0);
    tick();

    // Vector table: command A on port0, then MMUL B on port0 until it is taken
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      cmd_a = mk_cmd(vecs[r].code, vecs[r].typ, vecs[r].len, vecs[r].vrd);
      req0_cmd = cmd_a; req0_valid = 1'b1;
      at_neg();
      chk("vec_ready_a", req0_ready_o, 1);
      chk("vec_idle_a", idle_o, vecs[r].exp_err);
      tick();
      req0_cmd = mk_cmd(2'd1, 1'b0, 7'd0, vecs[r].vrd + 4'd1);
      gap = 0;
      for (int k = 1; k <= 300; k++) begin
        at_neg();
        if (k == 1) begin
          chk("vec_code", mpu_code_o, vecs[r].exp_err ? 2'd0 : vecs[r].code);
          chk("vec_err", err_o, vecs[r].exp_err);
        end
        if (k == 2 && vecs[r].exp_gap > 2) begin
          chk("vec_code_once", mpu_code_o, 0);
          chk("vec_len_held", mpu_mac_len_o, vecs[r].len);
        end
        if (req0_ready_o) begin
          gap = k;
          break;
        end
        tick();
      end
      chk("vec_gap", gap, vecs[r].exp_gap);
      tick();
      req0_valid = 1'b0;
      off = 0;
      for (int j = gap + 1; j <= gap + 400; j++) begin
        at_neg();
        if (idle_o) begin
          off = j;
          break;
        end
        tick();
      end
      chk("vec_idle_off", off, vecs[r].exp_idle);
    end

    // Slot back-pressure: MMAC L=4 then MMAC to another VR
    wait_idle();
    req0_cmd = mk_cmd(2'd3, 1'b0, 7'd4, 4'd3); req0_valid = 1'b1;
    at_neg();
    chk("slot_ready_t", req0_ready_o, 1);
    tick();
    req0_cmd = mk_cmd(2'd3, 1'b0, 7'd4, 4'd5);
    for (int k = 1; k <= 4; k++) begin
      at_neg();
      chk("slot_code", mpu_code_o, (k == 1) ? 2'd3 : 2'd0);
      chk("slot_len", mpu_mac_len_o, 4);
      chk("slot_ready", req0_ready_o, k == 4);
      tick();
    end
    req0_valid = 1'b0;
    at_neg();
    chk("slot_code_t5", mpu_code_o, 3);
    tick();

    // Hazard: same VR MMAC waits for t+6, MMUL on port1 slips in at t+4
    wait_idle();
    req0_cmd = mk_cmd(2'd3, 1'b0, 7'd4, 4'd3); req0_valid = 1'b1;
    at_neg();
    chk("haz_ready_t", req0_ready_o, 1);
    tick();
    req0_cmd = mk_cmd(2'd3, 1'b0, 7'd4, 4'd3);
    req1_cmd = mk_cmd(2'd1, 1'b0, 7'd0, 4'd7); req1_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      at_neg();
      chk("haz_ready0", req0_ready_o, k == 6);
      if (k <= 4) chk("haz_ready1", req1_ready_o, k == 4);
      if (k == 5) chk("haz_mmul_code", mpu_code_o, 1);
      tick();
      if (k == 4) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    at_neg();
    chk("haz_code_t7", mpu_code_o, 3);
    tick();

    // Round-robin from a fresh pointer: both ports stream MMUL
    wait_idle();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    exp_q.delete();
    req0_cmd = mk_cmd(2'd1, 1'b0, 7'd0, 4'd1); req0_valid = 1'b1;
    req1_cmd = mk_cmd(2'd1, 1'b1, 7'd0, 4'd2); req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      at_neg();
      chk("rr_ready0", req0_ready_o, (k % 2) == 0);
      chk("rr_ready1", req1_ready_o, (k % 2) == 1);
      if (k >= 1) chk("rr_code", mpu_code_o, 1);
      tick();
      if ((k % 2) == 0) req0_cmd = mk_cmd(2'd1, 1'b0, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
      else req1_cmd = mk_cmd(2'd1, 1'b1, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    at_neg();
    chk("rr_code_last", mpu_code_o, 1);
    tick();

    // Illegal code 2 on port1
    wait_idle();
    req1_cmd = mk_cmd(2'd2, 1'b0, 7'd8, 4'd6); req1_valid = 1'b1;
    at_neg();
    chk("ill_ready1", req1_ready_o, 1);
    chk("ill_idle_a", idle_o, 1);
    tick();
    req1_valid = 1'b0;
    at_neg();
    chk("ill_err", err_o, 1);
    chk("ill_code", mpu_code_o, 0);
    chk("ill_idle_a1", idle_o, 1);
    tick();
    at_neg();
    chk("ill_err_gone", err_o, 0);
    chk("ill_idle_a2", idle_o, 1);
    tick();

    // Single MMUL: idle low t..t+18, high at t+19
    wait_idle();
    req0_cmd = mk_cmd(2'd1, 1'b0, 7'd0, 4'd2); req0_valid = 1'b1;
    at_neg();
    chk("drn_ready", req0_ready_o, 1);
    chk("drn_idle_t", idle_o, 0);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      at_neg();
      chk("drn_idle", idle_o, k == 19);
      tick();
    end

    // Reset in the middle of a long MMAC
    wait_idle();
    req0_cmd = mk_cmd(2'd3, 1'b0, 7'd100, 4'd3); req0_valid = 1'b1;
    at_neg();
    chk("mid_ready", req0_ready_o, 1);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      at_neg();
      if (k == 5) chk("mid_busy", idle_o, 0);
      tick();
    end
    rstn = 1'b0;
    req0_cmd = mk_cmd(2'd1, 1'b0, 7'd0, 4'd4); req0_valid = 1'b1;
    req1_cmd = mk_cmd(2'd3, 1'b0, 7'd5, 4'd3); req1_valid = 1'b1;
    at_neg();
    chk("mid_rst_ready0", req0_ready_o, 0);
    chk("mid_rst_ready1", req1_ready_o, 0);
    tick();
    at_neg();
    chk("mid_rst_code", mpu_code_o, 0);
    tick();
    rstn = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q.delete();
    at_neg();
    chk("mid_rel_code", mpu_code_o, 0);
    chk("mid_rel_idle", idle_o, 1);
    chk("mid_rel_ready1", req1_ready_o, 0);
    tick();
    req1_valid = 1'b1;
    at_neg();
    chk("mid_rel_haz_clear", req1_ready_o, 1);
    tick();
    req1_valid = 1'b0;
    at_neg();
    chk("mid_rel_issue", mpu_code_o, 3);
    tick();
    wait_idle();

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
